// File: rtl/spi_frame_ctrl_if.sv
// Signal bundle between the SPI frame controller and its conditioners / shift register.
// The master side drives the conditioned SPI inputs; the slave side is the controller.
interface spi_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              cs_n;
    logic              sclk_pos;
    logic              sclk_neg;
    logic [DATA_W-1:0] sr_pdata;
    logic              sr_load;
    logic [DATA_W-1:0] sr_load_data;
    logic              miso_oe;
    logic              busy;

    modport master (
        output cs_n, sclk_pos, sclk_neg, sr_pdata,
        input  sr_load, sr_load_data, miso_oe, busy
    );

    modport slave (
        input  cs_n, sclk_pos, sclk_neg, sr_pdata,
        output sr_load, sr_load_data, miso_oe, busy
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI slave frame controller: decodes {addr, rw} + data frames against a 2^ADDR_W x DATA_W
// register memory, and drives the shift register parallel load and MISO enable for reads.
module spi_frame_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_frame_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        LATCH,
        WRITE_GET,
        COMMIT,
        READ_WAIT,
        READ_LOAD,
        READ_SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [ADDR_W-1:0] addr;
    logic              addr_ld;
    logic              mem_we;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (addr_ld) begin
                addr <= bus.sr_pdata[ADDR_W:1];
            end
        end
    end

    // Counting phases leave on the registered count of 8, so the word from the last
    // sclk_pos has settled on sr_pdata before LATCH/COMMIT consume it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_ld   = 1'b0;
        mem_we    = 1'b0;
        if (bus.cs_n) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = GET_ADDR;
                    cnt_nxt   = bus.sclk_pos ? 4'd1 : 4'd0;
                end
                GET_ADDR: begin
                    if (cnt == 4'd8) begin
                        state_nxt = LATCH;
                    end else if (bus.sclk_pos) begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                LATCH: begin
                    addr_ld   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = bus.sr_pdata[0] ? READ_WAIT : WRITE_GET;
                end
                WRITE_GET: begin
                    if (cnt == 4'd8) begin
                        state_nxt = COMMIT;
                    end else if (bus.sclk_pos) begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                COMMIT: begin
                    mem_we    = 1'b1;
                    state_nxt = DONE;
                end
                READ_WAIT: begin
                    if (bus.sclk_neg) begin
                        state_nxt = READ_LOAD;
                    end
                end
                READ_LOAD: begin
                    cnt_nxt   = '0;
                    state_nxt = READ_SHIFT;
                end
                READ_SHIFT: begin
                    if (cnt == 4'd8) begin
                        state_nxt = DONE;
                    end else if (bus.sclk_pos) begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Memory contents survive reset; only the write enable is qualified by it.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[addr] <= bus.sr_pdata;
        end
    end

    assign bus.sr_load_data = mem[addr];
    assign bus.sr_load      = (state == READ_LOAD);
    assign bus.miso_oe      = (state == READ_LOAD) || (state == READ_SHIFT);
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: a behavioural shift register feeds sr_pdata, stimulus
// queues the expected read words and MISO windows, and a negedge monitor checks them.
module tb_spi_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic mosi;
    logic [7:0] sr;

    always #5 clk = ~clk;

    spi_frame_ctrl_if #(.DATA_W(8)) bus ();

    spi_frame_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shift register model: samples MOSI on sclk_pos, parallel load wins over shifting.
    always @(posedge clk) begin
        if (bus.sr_load) sr <= bus.sr_load_data;
        else if (bus.sclk_pos) sr <= {sr[6:0], mosi};
    end
    assign bus.sr_pdata = sr;

    // kind 0: word expected on sr_load_data at the load strobe
    // kind 1: number of sclk_pos pulses seen while miso_oe was high
    typedef struct packed {
        logic       kind;
        logic [7:0] val;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   oe_pulses = 0;
    int   oe_loads = 0;
    logic oe_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.sr_load) begin
            oe_loads++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load got %02h want no load", bus.sr_load_data);
            end else begin
                e = expq.pop_front();
                if (e.kind !== 1'b0 || e.val !== bus.sr_load_data) begin
                    errors++;
                    $display("FAIL load_data got %02h want %02h (kind %0d)", bus.sr_load_data, e.val, e.kind);
                end
            end
        end
        if (bus.miso_oe && bus.sclk_pos) oe_pulses++;
        if (oe_prev && !bus.miso_oe) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_oe_window got %0d pulses want none", oe_pulses);
            end else begin
                e = expq.pop_front();
                if (e.kind !== 1'b1 || int'(e.val) != oe_pulses) begin
                    errors++;
                    $display("FAIL oe_pulses got %0d want %0d (kind %0d)", oe_pulses, e.val, e.kind);
                end
            end
            checks++;
            if (oe_loads != 1) begin
                errors++;
                $display("FAIL load_count got %0d want 1", oe_loads);
            end
            oe_pulses = 0;
            oe_loads  = 0;
        end
        oe_prev = bus.miso_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %02h want %02h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic kind, input logic [7:0] val);
        exp_t x;
        x.kind = kind;
        x.val  = val;
        expq.push_back(x);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        bus.sclk_pos = 1'b1;
        tick(1);
        bus.sclk_pos = 1'b0;
        tick(4);
        bus.sclk_neg = 1'b1;
        tick(1);
        bus.sclk_neg = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits);
        for (int i = 7; i >= 8 - nbits; i--) send_bit(v[i]);
    endtask

    // With coincident set, cs_n falls in the same cycle as the first sclk_pos.
    task automatic start_frame(input bit coincident);
        bus.cs_n = 1'b0;
        if (!coincident) tick(2);
    endtask

    task automatic end_frame;
        tick(2);
        chk("busy_in_done", {7'd0, bus.busy}, 8'd1);
        chk("miso_oe_in_done", {7'd0, bus.miso_oe}, 8'd0);
        bus.cs_n = 1'b1;
        tick(1);
        chk("busy_after_cs", {7'd0, bus.busy}, 8'd0);
        tick(2);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input bit coincident);
        start_frame(coincident);
        send_byte({a, 1'b0}, 8);
        send_byte(d, 8);
        end_frame();
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] d, input bit coincident);
        push_exp(1'b0, d);
        push_exp(1'b1, 8'd8);
        start_frame(coincident);
        send_byte({a, 1'b1}, 8);
        send_byte(8'h00, 8);
        end_frame();
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.cs_n     = 1'b0;
        bus.sclk_pos = 1'b0;
        bus.sclk_neg = 1'b0;
        mosi         = 1'b0;
        tick(1);

        // Reset held with the frame inputs active
        for (int i = 0; i < 3; i++) begin
            bus.sclk_pos = i[0];
            bus.sclk_neg = ~i[0];
            mosi         = ~i[0];
            tick(1);
        end
        chk("rst_sr_load", {7'd0, bus.sr_load}, 8'd0);
        chk("rst_miso_oe", {7'd0, bus.miso_oe}, 8'd0);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        bus.sclk_pos = 1'b0;
        bus.sclk_neg = 1'b0;
        bus.cs_n     = 1'b1;
        rst_n        = 1'b1;
        tick(1);
        chk("idle_after_rst", {7'd0, bus.busy}, 8'd0);
        tick(2);

        // Write then read back
        do_write(7'h15, 8'hA5, 1'b0);
        do_read(7'h15, 8'hA5, 1'b0);

        // Aborted write leaves the old contents
        do_write(7'h22, 8'h3C, 1'b0);
        start_frame(1'b0);
        send_byte({7'h22, 1'b0}, 8);
        send_byte(8'hFF, 5);
        bus.cs_n = 1'b1;
        tick(3);
        do_read(7'h22, 8'h3C, 1'b0);

        // Address extremes, no aliasing
        do_write(7'h00, 8'h11, 1'b0);
        do_write(7'h7F, 8'hEE, 1'b0);
        do_read(7'h00, 8'h11, 1'b0);
        do_read(7'h7F, 8'hEE, 1'b0);

        // cs_n raised after 3 data bits of a read
        push_exp(1'b0, 8'hA5);
        push_exp(1'b1, 8'd3);
        start_frame(1'b0);
        send_byte({7'h15, 1'b1}, 8);
        send_byte(8'h00, 3);
        chk("miso_oe_mid_read", {7'd0, bus.miso_oe}, 8'd1);
        bus.cs_n = 1'b1;
        tick(1);
        chk("abort_miso_oe", {7'd0, bus.miso_oe}, 8'd0);
        chk("abort_busy", {7'd0, bus.busy}, 8'd0);
        tick(2);
        do_read(7'h7F, 8'hEE, 1'b0);

        // First sclk_pos coincides with cs_n falling
        do_write(7'h40, 8'h5A, 1'b1);
        do_read(7'h40, 8'h5A, 1'b1);
        do_read(7'h00, 8'h11, 1'b1);

        tick(5);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got %0d want 0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

SPI slave frame controller with a 128×8 register memory. It consumes the conditioned chip-select and SCLK edge pulses produced by the input conditioners, along with the 8-bit parallel output of the serial shift register. It decodes each frame into address, read/write and data phases, performs memory writes, and drives the shift register's parallel-load port and the MISO output enable for reads. It sits between the input conditioners/shift register and the board-level MISO pin.

## Interface
- ADDR_W, 7: memory address width (depth = 2^ADDR_W).
- DATA_W, 8: word width; must equal the shift register width.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cs_n  in  1  conditioned chip select, active low.
- sclk_pos  in  1  one-cycle pulse per SCLK rising edge; the shift register samples MOSI on the same pulse.
- sclk_neg  in  1  one-cycle pulse per SCLK falling edge; the shift register shifts out on the same pulse.
- sr_pdata  in  DATA_W  shift register parallel output; valid the cycle after each sclk_pos.
- sr_load  out  1  one-cycle parallel-load strobe to the shift register.
- sr_load_data  out  DATA_W  word loaded into the shift register (mem[addr]).
- miso_oe  out  1  MISO tristate enable.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Frame format: 8 address bits (MSB first) = {addr[6:0], rw}, with rw=1 meaning read. For a write, 8 data bits follow.
- Internal registers: state, bit counter cnt[3:0], addr[ADDR_W-1:0], mem[2^ADDR_W].
- States and transitions:
  - IDLE → GET_ADDR when cs_n=0.
  - GET_ADDR: cnt increments on sclk_pos. At cnt=8 → LATCH.
  - LATCH (1 cycle): addr ← sr_pdata[7:1]; cnt ← 0. Goes to READ_WAIT if sr_pdata[0]=1, otherwise to WRITE_GET.
  - WRITE_GET: cnt increments on sclk_pos. At cnt=8 → COMMIT.
  - COMMIT (1 cycle): mem[addr] ← sr_pdata → DONE.
  - READ_WAIT: waits for sclk_neg → READ_LOAD.
  - READ_LOAD (1 cycle): sr_load=1; cnt ← 0 → READ_SHIFT.
  - READ_SHIFT: cnt increments on sclk_pos. At cnt=8 → DONE.
  - DONE: holds until cs_n=1.
- cs_n=1 forces IDLE from any state, with cnt ← 0. This has priority over all other transitions.
  - A COMMIT that was not reached writes nothing (aborted writes leave memory unchanged).
- A sclk_pos arriving in the IDLE→GET_ADDR transition cycle is counted (cnt=1 on entry).
- sr_load_data = mem[addr], read combinationally from the latched addr.
- miso_oe = 1 only in READ_LOAD and READ_SHIFT.
- sclk pulses in LATCH, COMMIT, READ_LOAD and DONE are ignored by the counter.
- Pulses beyond 8 data bits in DONE have no effect.
- Reset values: state=IDLE, cnt=0, addr=0, sr_load=0, miso_oe=0, busy=0.
  - Memory contents are not reset and are preserved across reset.
- Reset mid-frame: IDLE on the next edge. No memory write occurs unless COMMIT had already been executed.

## Timing
- Address latched 1 cycle after the 8th sclk_pos pulse.
- Write: mem updated at the clock edge 2 cycles after the 16th sclk_pos (count cycle, then COMMIT). The new value is visible on sr_load_data the following cycle if addr matches.
- Read:
  - sr_load is high exactly 1 cycle, the cycle after the first sclk_neg following the address phase. The load overrides that cycle's shift in the shift register, so its MSB drives MISO before the next SCLK rise.
  - miso_oe rises with sr_load and falls the cycle after the 8th sclk_pos of the data phase.
- cs_n deassertion clears miso_oe and busy on the next clock edge, whatever the current state.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with cs_n=0 and pulses toggling → sr_load=0, miso_oe=0, busy=0; state IDLE on release.
- Write then read: frame {0x15,0} + data 0xA5, raise cs_n; then frame {0x15,1} → single sr_load pulse with sr_load_data=0xA5, miso_oe high for 8 sclk_pos, then low.
- Aborted write: frame {0x22,0}, raise cs_n after 5 data bits; then read 0x22 → previous contents returned (write preloaded 0x3C → 0x3C).
- Address extremes: write 0x00 and 0x7F with 0x11 and 0xEE, then read both → 0x11 and 0xEE, with no aliasing.
- cs_n mid-read: raise cs_n after 3 data bits of a read → miso_oe=0 and busy=0 on the next edge; the next frame decodes correctly from bit 0.
- Coincident start: sclk_pos in the same cycle cs_n falls, followed by 7 more pulses → address latched after 8 total pulses, and the following read/write behaves as in scenario 2.
